// File: rtl/mdu_writeback.sv
// mdu_writeback: iterative RV32M multiply/divide unit feeding the register file write port.
//
// A request is taken only while idle. The unit then runs WIDTH shift-add (multiply) or
// restoring-division (divide) steps on operand magnitudes, applies sign correction and the
// divide-by-zero / overflow cases in one fix-up cycle, and finally presents a single-cycle
// write request. The latency is the same for every operation, including the special cases.
//
// Ports:
//   clk     in   system clock, rising edge
//   rst     in   asynchronous active-high reset
//   start   in   request, sampled only while idle
//   funct3  in   000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
//   op_a    in   rs1 value (multiplicand / dividend)
//   op_b    in   rs2 value (multiplier / divisor)
//   rd_in   in   destination register index
//   busy    out  high whenever the unit is not idle
//   done    out  one-cycle result-valid pulse
//   WE      out  register file write enable, suppressed for x0
//   AD3     out  destination index of the last result
//   WD3     out  last result, held until the next operation's fix-up cycle
module mdu_writeback #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [4:0]       rd_in,
  output logic             busy,
  output logic             done,
  output logic             WE,
  output logic [4:0]       AD3,
  output logic [WIDTH-1:0] WD3
);

  localparam int unsigned     CntW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MinVal = {1'b1, {(WIDTH - 1){1'b0}}};

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StCalc = 2'd1;
  localparam logic [1:0] StFix  = 2'd2;
  localparam logic [1:0] StDone = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [2:0]         f3_q;
  logic [4:0]         rd_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   mag_a_q;
  logic [WIDTH-1:0]   mag_b_q;
  logic               neg_a_q;
  logic               neg_b_q;
  logic               div0_q;
  logic               ovf_q;
  // Shared accumulator: multiply keeps {partial product, multiplier}, divide keeps
  // {partial remainder, dividend/quotient}.
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [4:0]         ad3_q;
  logic [WIDTH-1:0]   wd3_q;

  // ---------------------------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------------------------
  logic             sgn_a_in, sgn_b_in;
  logic             neg_a_in, neg_b_in;
  logic [WIDTH-1:0] mag_a_in, mag_b_in;
  logic             div0_in, ovf_in;

  always_comb begin
    sgn_a_in = 1'b0;
    sgn_b_in = 1'b0;
    case (funct3)
      3'b001, 3'b100, 3'b110: begin
        sgn_a_in = 1'b1;
        sgn_b_in = 1'b1;
      end
      3'b010:  sgn_a_in = 1'b1;
      default: ;
    endcase
  end

  assign neg_a_in = sgn_a_in & op_a[WIDTH-1];
  assign neg_b_in = sgn_b_in & op_b[WIDTH-1];
  assign mag_a_in = neg_a_in ? -op_a : op_a;
  assign mag_b_in = neg_b_in ? -op_b : op_b;
  assign div0_in  = (op_b == '0);
  // Only meaningful for the signed divide ops; the result mux ignores it elsewhere.
  assign ovf_in   = (op_a == MinVal) && (op_b == '1);

  // ---------------------------------------------------------------------------------------------
  // Iteration step
  // ---------------------------------------------------------------------------------------------
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_step;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] div_step;

  // Right-shifting shift-add: the multiplier LSB decides whether to add the multiplicand
  // into the upper half, then the whole accumulator shifts right by one.
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                    {1'b0, (acc_q[0] ? mag_a_q : {WIDTH{1'b0}})};
  assign mul_step = {mul_sum, acc_q[WIDTH-1:1]};

  // Restoring division: bring in the next dividend bit, trial-subtract the divisor and keep
  // the difference only when it did not go negative.
  assign div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, mag_b_q};
  assign div_step  = div_diff[WIDTH] ? {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                     : {div_diff[WIDTH-1:0],  acc_q[WIDTH-2:0], 1'b1};

  // ---------------------------------------------------------------------------------------------
  // Sign correction and special cases
  // ---------------------------------------------------------------------------------------------
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   quo_s, rem_s;
  logic [WIDTH-1:0]   result;

  assign prod_s = (neg_a_q ^ neg_b_q) ? -acc_q : acc_q;
  assign quo_s  = (neg_a_q ^ neg_b_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  // Remainder follows the dividend sign.
  assign rem_s  = neg_a_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

  always_comb begin
    result = '0;
    case (f3_q)
      3'b000:                 result = prod_s[WIDTH-1:0];
      3'b001, 3'b010, 3'b011: result = prod_s[2*WIDTH-1:WIDTH];
      3'b100:                 result = div0_q ? '1 : (ovf_q ? MinVal : quo_s);
      3'b101:                 result = div0_q ? '1 : quo_s;
      3'b110:                 result = div0_q ? a_q : (ovf_q ? '0 : rem_s);
      default:                result = div0_q ? a_q : rem_s;
    endcase
  end

  // ---------------------------------------------------------------------------------------------
  // Sequencing
  // ---------------------------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StCalc;
          cnt_d   = '0;
          acc_d   = {{WIDTH{1'b0}}, (funct3[2] ? mag_a_in : mag_b_in)};
        end
      end
      StCalc: begin
        cnt_d = cnt_q + CntW'(1);
        acc_d = f3_q[2] ? div_step : mul_step;
        if (cnt_q == CntLast) begin
          state_d = StFix;
        end
      end
      StFix:   state_d = StDone;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      acc_q   <= '0;
      f3_q    <= '0;
      rd_q    <= '0;
      a_q     <= '0;
      mag_a_q <= '0;
      mag_b_q <= '0;
      neg_a_q <= 1'b0;
      neg_b_q <= 1'b0;
      div0_q  <= 1'b0;
      ovf_q   <= 1'b0;
      ad3_q   <= '0;
      wd3_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      if ((state_q == StIdle) && start) begin
        f3_q    <= funct3;
        rd_q    <= rd_in;
        a_q     <= op_a;
        mag_a_q <= mag_a_in;
        mag_b_q <= mag_b_in;
        neg_a_q <= neg_a_in;
        neg_b_q <= neg_b_in;
        div0_q  <= div0_in;
        ovf_q   <= ovf_in;
      end
      if (state_q == StFix) begin
        wd3_q <= result;
        ad3_q <= rd_q;
      end
    end
  end

  assign busy = (state_q != StIdle);
  assign done = (state_q == StDone);
  // The register file does not protect x0, so never write it.
  assign WE   = done & (rd_q != 5'd0);
  assign AD3  = ad3_q;
  assign WD3  = wd3_q;

endmodule

// File: doc/mdu_writeback.md
Name: mdu_writeback

Overview:
- Iterative multi-cycle RV32M multiply/divide unit that sits directly upstream of the register file write port.
- Accepts operands read from RD1/RD2 plus the destination register index.
- Computes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU over a fixed number of cycles.
- Delivers the result as a one-cycle write request (WE/AD3/WD3) while the core stalls on busy.

Parameters:
- WIDTH, 32, operand/result width; iteration count equals WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- funct3  input  3  op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- op_a  input  WIDTH  rs1 value (dividend / multiplicand).
- op_b  input  WIDTH  rs2 value (divisor / multiplier).
- rd_in  input  5  destination register index.
- busy  output  1  high whenever state is not IDLE; core stalls the PC.
- done  output  1  one-cycle pulse, result valid.
- WE  output  1  register file write enable; equals done AND (rd_q != 0).
- AD3  output  5  latched destination index.
- WD3  output  WIDTH  result; held stable until the next accepted start.

Behaviour:
- Reset (async, immediate): state IDLE; busy=0, done=0, WE=0, AD3=0, WD3=0; counter, accumulators and latched operands cleared.
- States: IDLE -> CALC -> FIX -> DONE -> IDLE.
- IDLE: on an edge with start=1, latch funct3, rd_in, op_a, op_b.
  - Record sign flags per op: MULH both signed; MULHSU only op_a signed; DIV/REM both signed; all other ops unsigned.
  - Latch absolute magnitudes.
  - Clear the counter; go to CALC.
- CALC: exactly WIDTH edges.
  - Multiply: shift-add, 2*WIDTH-bit unsigned product of magnitudes.
  - Divide: restoring division, one quotient bit per cycle, MSB first; WIDTH+1-bit partial remainder.
  - Counter reaches WIDTH-1 on the last CALC edge, then go to FIX.
- FIX: single edge; apply sign correction and special cases, register WD3, go to DONE.
  - Product negated if the sign flags differ (for MULHSU, the op_a sign alone).
  - MUL selects low WIDTH bits; MULH/MULHSU/MULHU select high WIDTH bits.
  - Quotient negated if the dividend and divisor signs differ; remainder takes the dividend sign.
  - Divide by zero (op_b == 0): DIV/DIVU -> all ones; REM/REMU -> original op_a.
  - Signed overflow (DIV/REM with op_a = 0x80000000, op_b = 0xFFFFFFFF): DIV -> 0x80000000; REM -> 0.
  - Special cases use the same latency; there is no early exit.
- DONE: done=1 and WE=(AD3!=0) for exactly one cycle, then IDLE.
  - rd=0 never produces a write, because the register file does not protect x0.
- Latency: start accepted at edge E0; CALC spans E1..E32; FIX at E33; done high between E33 and E34; busy high from E0 through E34.
- start while busy: ignored; no queuing and no change to the latched operands.
- start in the same cycle that state returns to IDLE: accepted on the next edge only if still asserted (IDLE samples).
- Operand inputs may change after acceptance without effect.
- Reset during CALC/FIX/DONE: aborts immediately; no write is issued; WD3 returns to 0.
- WD3/AD3 remain stable after done until the next accepted start updates them in FIX.

Test Plan:
- MUL 7 x -3 (op_a=7, op_b=0xFFFFFFFD), rd=5 -> done and WE pulse exactly 34 cycles after start; WD3=0xFFFFFFEB; AD3=5; busy low afterward.
- MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- Divide by zero: DIV 5/0 -> 0xFFFFFFFF, REM 5/0 -> 5. Overflow: DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0. Latency is still 34 cycles.
- rd_in=0 with MUL 3x4 -> done pulses, WD3=12, WE stays 0. Second start pulsed mid-CALC -> ignored; WD3 reflects the first operation only.
- Assert rst at cycle 10 of a DIV -> busy, done and WE drop immediately, WD3=0, no write occurs. A new start after reset completes normally.
